// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-FF sync, mid-bit 3-sample majority vote, stop/parity check.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_os #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int unsigned TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW       = $clog2(OVERSAMPLE);
  localparam int unsigned BW       = 4;
  localparam int unsigned MID      = OVERSAMPLE / 2;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1 || TICK_DIV < 1) begin : g_bad_param
    $error("uart_rx_os: unsupported parameter set");
  end

  logic                 rx_meta, rx_sync, rx_prev;
  logic [2:0]           state, state_d;
  logic [TW-1:0]        tick_cnt, tick_cnt_d;
  logic [SW-1:0]        s_cnt, s_cnt_d;
  logic [BW-1:0]        bit_cnt, bit_cnt_d;
  logic                 stop_cnt, stop_cnt_d;
  logic [1:0]           samp, samp_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 ferr_acc, ferr_acc_d;
  logic [DATA_BITS-1:0] rx_data_d;
  logic                 rx_valid_d, frame_err_d, parity_err_d;
  logic                 par_bit, par_bit_d;
  logic                 tick, decide, bit_end, vote;

  // Two-stage synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign tick    = (tick_cnt == TW'(TICK_DIV - 1));
  assign decide  = tick && (s_cnt == SW'(MID + 1));
  assign bit_end = tick && (s_cnt == SW'(OVERSAMPLE - 1));
  assign vote    = (samp[0] & samp[1]) | (samp[0] & rx_sync) | (samp[1] & rx_sync);
  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      s_cnt      <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      samp       <= '0;
      shreg      <= '0;
      ferr_acc   <= 1'b0;
      par_bit    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_d;
      tick_cnt   <= tick_cnt_d;
      s_cnt      <= s_cnt_d;
      bit_cnt    <= bit_cnt_d;
      stop_cnt   <= stop_cnt_d;
      samp       <= samp_d;
      shreg      <= shreg_d;
      ferr_acc   <= ferr_acc_d;
      par_bit    <= par_bit_d;
      rx_data    <= rx_data_d;
      rx_valid   <= rx_valid_d;
      frame_err  <= frame_err_d;
      parity_err <= parity_err_d;
    end
  end

  always_comb begin
    state_d      = state;
    tick_cnt_d   = tick_cnt;
    s_cnt_d      = s_cnt;
    bit_cnt_d    = bit_cnt;
    stop_cnt_d   = stop_cnt;
    samp_d       = samp;
    shreg_d      = shreg;
    ferr_acc_d   = ferr_acc;
    par_bit_d    = par_bit;
    rx_data_d    = rx_data;
    rx_valid_d   = 1'b0;
    frame_err_d  = frame_err;
    parity_err_d = parity_err;

    // Bit timing: tick divider and per-bit sample counter with the two early vote samples
    if (state != IDLE) begin
      tick_cnt_d = tick ? '0 : tick_cnt + TW'(1);
      if (tick) begin
        s_cnt_d = bit_end ? '0 : s_cnt + SW'(1);
        if (s_cnt == SW'(MID - 1)) samp_d[0] = rx_sync;
        if (s_cnt == SW'(MID))     samp_d[1] = rx_sync;
      end
    end

    case (state)
      IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_d    = START;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          ferr_acc_d = 1'b0;
        end
      end
      START: begin
        if (decide && vote)  state_d = IDLE;
        else if (bit_end)    state_d = DATA;
      end
      DATA: begin
        if (decide) shreg_d = {vote, shreg[DATA_BITS-1:1]};
        if (bit_end) begin
          if (bit_cnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt + BW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (decide)  par_bit_d = vote;
        if (bit_end) state_d   = STOP;
      end
`endif
      STOP: begin
        if (decide) begin
          if (!vote) ferr_acc_d = 1'b1;
          // Frame completes at the last stop-bit decision so a following start bit is not missed
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            state_d     = IDLE;
            rx_valid_d  = 1'b1;
            rx_data_d   = shreg;
            frame_err_d = ferr_acc | ~vote;
`ifdef UART_RX_PARITY_EN
            parity_err_d = ((^shreg) ^ par_bit) != PARITY_ODD[0];
`else
            parity_err_d = 1'b0;
`endif
          end
        end else if (bit_end) begin
          stop_cnt_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      tick_cnt_d = '0;
      s_cnt_d    = '0;
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed and randomized frames against a frame-level model.
// Runs at a reduced clock/baud ratio (TICK_DIV = floor(1e6/153600) = 6) to keep run time short.
module tb_uart_rx_os;

  localparam int unsigned CLK_FREQ = 1_000_000;
  localparam int unsigned BAUD     = 9600;
  localparam int unsigned OS       = 16;
  localparam int unsigned DB       = 8;
  localparam int unsigned SB       = 1;
  localparam int unsigned PODD     = 0;
  localparam int unsigned TICK_DIV = 6;
  localparam int unsigned BIT_CLKS = TICK_DIV * OS;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned FRAME_BITS = 1 + DB + 1 + SB;
`else
  localparam int unsigned FRAME_BITS = 1 + DB + SB;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx  = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid, rx_busy, frame_err, parity_err;

  int total = 0;
  int bad   = 0;
  logic [DB+1:0] got_q[$];

  uart_rx_os #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(DB), .STOP_BITS(SB), .PARITY_ODD(PODD)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_busy(rx_busy), .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // Capture every clock where rx_valid is high: a stretched pulse shows up as an extra entry
  always @(negedge clk) begin
    if (rx_valid) got_q.push_back({parity_err, frame_err, rx_data});
  end

  // Frame-level reference: {parity_err, frame_err, data}
  function automatic logic [DB+1:0] model(input logic [DB-1:0] d, input logic [1:0] stop, input logic par);
    logic fe, pe;
    fe = 1'b0;
    for (int i = 0; i < int'(SB); i++) if (!stop[i]) fe = 1'b1;
`ifdef UART_RX_PARITY_EN
    pe = ((^d) ^ par) != PODD[0];
`else
    pe = 1'b0 & par;
`endif
    return {pe, fe, d};
  endfunction

  function automatic logic good_par(input logic [DB-1:0] d);
    return (^d) ^ PODD[0];
  endfunction

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic [1:0] stop, input logic par);
    drive_bit(1'b0);
    for (int i = 0; i < int'(DB); i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`endif
    for (int i = 0; i < int'(SB); i++) drive_bit(stop[i]);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (rx_valid !== 1'b0)   begin bad++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    total++; if (rx_data !== '0)      begin bad++; $display("FAIL reset_rx_data got=%h exp=0", rx_data); end
    total++; if (frame_err !== 1'b0)  begin bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_parity_err got=%b exp=0", parity_err); end
    total++; if (rx_busy !== 1'b0)    begin bad++; $display("FAIL reset_rx_busy got=%b exp=0", rx_busy); end
    rst = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    total++; if (got_q.size() != 0)   begin bad++; $display("FAIL reset_no_valid got=%0d exp=0", got_q.size()); end
  endtask

  task automatic test_basic;
    logic [DB-1:0] d;
    logic [DB+1:0] exp_v, got_v;
    for (int k = 0; k < 5; k++) begin
      d = (k == 0) ? DB'(8'h64) : DB'($urandom);
      exp_v = model(d, 2'b11, good_par(d));
      got_q.delete();
      send_frame(d, 2'b11, good_par(d));
      drive_bit(1'b1);
      total++;
      if (got_q.size() != 1) begin
        bad++; $display("FAIL basic_count[%0d] got=%0d exp=1", k, got_q.size());
      end else begin
        got_v = got_q.pop_front();
        if (got_v !== exp_v) begin bad++; $display("FAIL basic_frame[%0d] got=%h exp=%h", k, got_v, exp_v); end
      end
      total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL basic_busy[%0d] got=%b exp=0", k, rx_busy); end
      repeat (2) drive_bit(1'b1);
      total++; if (rx_data !== d) begin bad++; $display("FAIL basic_hold[%0d] got=%h exp=%h", k, rx_data, d); end
    end
  endtask

  task automatic test_false_start;
    logic [DB+1:0] exp_v, got_v;
    got_q.delete();
    rx = 1'b0;
    repeat (TICK_DIV) @(negedge clk);
    total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL false_start_busy got=%b exp=1", rx_busy); end
    repeat (2 * TICK_DIV) @(negedge clk);
    repeat (2) drive_bit(1'b1);
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL false_start_idle got=%b exp=0", rx_busy); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL false_start_valid got=%0d exp=0", got_q.size()); end
    exp_v = model(DB'(8'h3A), 2'b11, good_par(DB'(8'h3A)));
    send_frame(DB'(8'h3A), 2'b11, good_par(DB'(8'h3A)));
    drive_bit(1'b1);
    total++;
    if (got_q.size() != 1) begin
      bad++; $display("FAIL false_start_next_count got=%0d exp=1", got_q.size());
    end else begin
      got_v = got_q.pop_front();
      if (got_v !== exp_v) begin bad++; $display("FAIL false_start_next got=%h exp=%h", got_v, exp_v); end
    end
  endtask

  task automatic test_frame_err;
    logic [DB+1:0] exp_q[$];
    logic [DB+1:0] got_v;
    got_q.delete();
    exp_q.push_back(model(DB'(8'hA5), 2'b00, good_par(DB'(8'hA5))));
    send_frame(DB'(8'hA5), 2'b00, good_par(DB'(8'hA5)));
    repeat (2 * FRAME_BITS) drive_bit(1'b0);
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL break_busy got=%b exp=0", rx_busy); end
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL break_count got=%0d exp=1", got_q.size()); end
    drive_bit(1'b1);
    exp_q.push_back(model(DB'(8'h11), 2'b11, good_par(DB'(8'h11))));
    send_frame(DB'(8'h11), 2'b11, good_par(DB'(8'h11)));
    drive_bit(1'b1);
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL ferr_total_count got=%0d exp=2", got_q.size()); end
    for (int i = 0; i < 2 && got_q.size() > 0; i++) begin
      got_v = got_q.pop_front();
      total++; if (got_v !== exp_q[i]) begin bad++; $display("FAIL ferr_frame[%0d] got=%h exp=%h", i, got_v, exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [DB-1:0] d[4];
    logic [DB+1:0] got_v, exp_v;
    d[0] = DB'($urandom); d[1] = DB'($urandom); d[2] = DB'(8'h55); d[3] = DB'(8'hAA);
    got_q.delete();
    for (int i = 0; i < 4; i++) send_frame(d[i], 2'b11, good_par(d[i]));
    drive_bit(1'b1);
    total++; if (got_q.size() != 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < 4 && got_q.size() > 0; i++) begin
      got_v = got_q.pop_front();
      exp_v = model(d[i], 2'b11, good_par(d[i]));
      total++; if (got_v !== exp_v) begin bad++; $display("FAIL b2b_frame[%0d] got=%h exp=%h", i, got_v, exp_v); end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [DB-1:0] d;
    logic [DB+1:0] got_v, exp_v;
    d = DB'(8'h64);
    got_q.delete();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    repeat (BIT_CLKS / 2) @(negedge clk);
    total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b exp=1", rx_busy); end
    rst = 1'b0;
    #1;
    total++; if ({rx_valid, rx_busy, frame_err, parity_err} !== 4'b0000)
      begin bad++; $display("FAIL mid_reset_flags got=%b exp=0000", {rx_valid, rx_busy, frame_err, parity_err}); end
    total++; if (rx_data !== '0) begin bad++; $display("FAIL mid_reset_data got=%h exp=0", rx_data); end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    drive_bit(1'b1);
    exp_v = model(d, 2'b11, good_par(d));
    send_frame(d, 2'b11, good_par(d));
    drive_bit(1'b1);
    total++;
    if (got_q.size() != 1) begin
      bad++; $display("FAIL mid_after_count got=%0d exp=1", got_q.size());
    end else begin
      got_v = got_q.pop_front();
      if (got_v !== exp_v) begin bad++; $display("FAIL mid_after_frame got=%h exp=%h", got_v, exp_v); end
    end
  endtask

  task automatic test_random;
    logic [DB-1:0] d;
    logic [1:0]    stop;
    logic          par;
    logic [DB+1:0] exp_q[$];
    logic [DB+1:0] got_v;
    int n;
    got_q.delete();
    for (int k = 0; k < 8; k++) begin
      d    = DB'($urandom);
      stop = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b11;
      par  = 1'($urandom);
      exp_q.push_back(model(d, stop, par));
      send_frame(d, stop, par);
      // An errored stop leaves the line low, so the line must return high before the next start
      n = (stop == 2'b11) ? $urandom_range(0, 2) : $urandom_range(1, 2);
      repeat (n) drive_bit(1'b1);
    end
    drive_bit(1'b1);
    total++; if (got_q.size() != 8) begin bad++; $display("FAIL rand_count got=%0d exp=8", got_q.size()); end
    for (int i = 0; i < 8 && got_q.size() > 0; i++) begin
      got_v = got_q.pop_front();
      total++; if (got_v !== exp_q[i]) begin bad++; $display("FAIL rand_frame[%0d] got=%h exp=%h", i, got_v, exp_q[i]); end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    logic [DB+1:0] got_v;
    got_q.delete();
    send_frame(DB'(8'h64), 2'b11, 1'b1);
    drive_bit(1'b1);
    send_frame(DB'(8'h64), 2'b11, 1'b0);
    drive_bit(1'b1);
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL parity_count got=%0d exp=2", got_q.size()); end
    if (got_q.size() > 0) begin
      got_v = got_q.pop_front();
      total++; if (got_v[DB+1] !== 1'b0) begin bad++; $display("FAIL parity_good got=%b exp=0", got_v[DB+1]); end
    end
    if (got_q.size() > 0) begin
      got_v = got_q.pop_front();
      total++; if (got_v[DB+1] !== 1'b1) begin bad++; $display("FAIL parity_bad got=%b exp=1", got_v[DB+1]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
